// File: rtl/hex_wr_arbiter.sv
// Two-requester round-robin write arbiter feeding a 16-byte hex register file.
// Misaligned half/word writes are broken into consecutive byte stores.
module hex_wr_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_mode_i,
    input  logic [3:0]  req0_addr_i,
    input  logic [31:0] req0_data_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_mode_i,
    input  logic [3:0]  req1_addr_i,
    input  logic [31:0] req1_data_i,
    output logic        st_en_o,
    output logic [2:0]  datamode_o,
    output logic [3:0]  addr_o,
    output logic [31:0] data_o,
    output logic        src_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SPLIT = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [1:0]  hmode_q, hmode_d;
    logic [3:0]  haddr_q, haddr_d;
    logic [31:0] hdata_q, hdata_d;
    logic        hsrc_q, hsrc_d;
    logic [1:0]  idx_q, idx_d;
    logic        st_en_q, st_en_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        src_q, src_d;

    logic        gnt0, gnt1, acc;
    logic [2:0]  in_mode;
    logic [3:0]  in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_nmode;
    logic        in_aligned;
    logic [1:0]  last_idx, idx_nxt;
    logic [7:0]  split_byte;

    // last_q names the requester granted most recently; the other one wins a tie
    assign gnt0 = req0_valid_i & (~req1_valid_i | last_q);
    assign gnt1 = req1_valid_i & (~req0_valid_i | ~last_q);
    assign req0_ready_o = ~rst_i & (state_q == IDLE) & gnt0;
    assign req1_ready_o = ~rst_i & (state_q == IDLE) & gnt1;
    assign acc = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);

    assign in_mode    = gnt1 ? req1_mode_i : req0_mode_i;
    assign in_addr    = gnt1 ? req1_addr_i : req0_addr_i;
    assign in_data    = gnt1 ? req1_data_i : req0_data_i;
    assign in_nmode   = (in_mode >= 3'd2) ? 2'd2 : in_mode[1:0];
    assign in_aligned = (in_nmode == 2'd0)
                      | ((in_nmode == 2'd1) & ~in_addr[0])
                      | ((in_nmode == 2'd2) & (in_addr[1:0] == 2'b00));

    assign last_idx   = (hmode_q == 2'd1) ? 2'd1 : 2'd3;
    assign idx_nxt    = idx_q + 2'd1;
    assign split_byte = hdata_q[{idx_nxt, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hmode_d = hmode_q;
        haddr_d = haddr_q;
        hdata_d = hdata_q;
        hsrc_d  = hsrc_q;
        idx_d   = idx_q;
        st_en_d = 1'b0;
        mode_d  = 2'd0;
        addr_d  = 4'd0;
        data_d  = 32'd0;
        src_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    last_d  = gnt1;
                    hmode_d = in_nmode;
                    haddr_d = in_addr;
                    hdata_d = in_data;
                    hsrc_d  = gnt1;
                    idx_d   = 2'd0;
                    // first store is presented straight from the request so it lands one cycle after accept
                    st_en_d = 1'b1;
                    addr_d  = in_addr;
                    src_d   = gnt1;
                    if (in_aligned) begin
                        state_d = ISSUE;
                        mode_d  = in_nmode;
                        data_d  = in_data;
                    end else begin
                        state_d = SPLIT;
                        data_d  = {24'd0, in_data[7:0]};
                    end
                end
            end
            ISSUE: state_d = IDLE;
            SPLIT: begin
                if (idx_q == last_idx) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_nxt;
                    st_en_d = 1'b1;
                    addr_d  = haddr_q + {2'b00, idx_nxt};
                    data_d  = {24'd0, split_byte};
                    src_d   = hsrc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hmode_q <= 2'd0;
            haddr_q <= 4'd0;
            hdata_q <= 32'd0;
            hsrc_q  <= 1'b0;
            idx_q   <= 2'd0;
            st_en_q <= 1'b0;
            mode_q  <= 2'd0;
            addr_q  <= 4'd0;
            data_q  <= 32'd0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hmode_q <= hmode_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
            hsrc_q  <= hsrc_d;
            idx_q   <= idx_d;
            st_en_q <= st_en_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign st_en_o    = st_en_q;
    assign datamode_o = {1'b0, mode_q};
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign src_o      = src_q;
    assign busy_o     = (state_q != IDLE);
endmodule

// File: doc/hex_wr_arbiter.md
HEX_WR_ARBITER -- requirements
Module: hex_wr_arbiter

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; no parameters.
REQ-002 clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 req0_valid_i  input  1  requester 0 (CPU store path) write request.
REQ-005 req0_ready_o  output  1  requester 0 accepted this cycle.
REQ-006 req0_mode_i  input  3  0 byte, 1 half-word, 2..7 word.
REQ-007 req0_addr_i  input  4  byte address into 16-byte hex register file.
REQ-008 req0_data_i  input  32  write data, little-endian, byte 0 in [7:0].
REQ-009 req1_valid_i, req1_ready_o, req1_mode_i, req1_addr_i, req1_data_i SHALL mirror REQ-004..008 for requester 1 (debug injector).
REQ-010 st_en_o  output  1  store strobe to hex register file.
REQ-011 datamode_o  output  3  normalized mode, only 0, 1 or 2.
REQ-012 addr_o  output  4  store byte address.
REQ-013 data_o  output  32  store data.
REQ-014 src_o  output  1  requester owning current store.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, SPLIT.
REQ-017 Handshake: accept when valid_i and ready_o both high at a rising edge; requester holds valid and payload stable until accepted.
REQ-018 ready_o SHALL be high only in IDLE and only for the arbitration winner; never both high.
REQ-019 Arbitration: round-robin via last-grant pointer; with both valid, the requester not granted last wins; with one valid, it wins.
REQ-020 Pointer SHALL update only on accept.
REQ-021 On accept: latch mode, addr, data, source into a holding register.
REQ-022 Alignment: byte always aligned; half aligned iff addr[0]=0; word (mode 2..7) aligned iff addr[1:0]=0.
REQ-023 Aligned: next state ISSUE; one cycle st_en_o=1, datamode_o = 0/1/2 normalized, addr_o = latched addr, data_o = latched data; then IDLE.
REQ-024 Misaligned: next state SPLIT; issue k byte stores (k=2 half, 4 word) on k consecutive cycles, then IDLE.
REQ-025 Split byte i (i=0..k-1): st_en_o=1, datamode_o=0, addr_o = (addr+i) mod 16, data_o[7:0] = data byte i, data_o[31:8]=0.
REQ-026 Address arithmetic SHALL be 4-bit and wrap 0xF->0x0.
REQ-027 Latency: request accepted at edge N produces its first st_en_o in the cycle after edge N; throughput is one aligned store per 2 cycles.
REQ-028 All outputs except ready_o SHALL be registered; st_en_o=0 and data_o/addr_o/datamode_o=0 whenever no store is issued.
REQ-029 src_o SHALL equal the latched source during every issue cycle, else 0.
REQ-030 Valid requests arriving while busy SHALL wait, unacknowledged and unchanged.

Reset
REQ-031 rst_i high at an edge: state IDLE, pointer = requester 1, so requester 0 wins next tie; holding register cleared.
REQ-032 During reset, all outputs SHALL be 0, including both ready_o.
REQ-033 Reset mid-ISSUE or mid-SPLIT aborts remaining stores; no st_en_o after the reset edge.

Verification
REQ-034 Byte write: req0 mode0 addr 0x5 data 0x000000AB -> accepted, next cycle st_en_o=1, mode 0, addr 0x5, data 0xAB, src 0.
REQ-035 Tie after reset: req0 and req1 both valid -> req0 accepted first, req1 accepted 2 cycles later; grants alternate while both stay valid.
REQ-036 Misaligned word: req1 mode2 addr 0xE data 0x44332211 -> 4 byte stores at addr E/F/0/1 with data 11/22/33/44, src 1, then IDLE.
REQ-037 Misaligned half: req0 mode1 addr 0x3 data 0x0000BEEF -> byte stores at addr 3 data EF, then addr 4 data BE.
REQ-038 Mode 3'd5 aligned: addr 0x8 data 0xDEADBEEF -> single store, datamode_o=2, addr 0x8, data 0xDEADBEEF.
REQ-039 Reset after 2nd byte of REQ-036 split -> st_en_o=0 from next cycle, busy_o=0; next tie grants req0.
